// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared state encoding and defaults for the stepper axis controller
package stepper_pkg;

  localparam int          POS_W_DEF    = 16;
  localparam logic [31:0] MIN_HALF_DEF = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOME,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser for a raw asynchronous input, async reset to 0
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/stepper_axis_ctrl.sv
// rtl/stepper_axis_ctrl.sv - STEP/DIR/ENABLE sequencer with homing and absolute position tracking
module stepper_axis_ctrl
  import stepper_pkg::*;
#(
  parameter int                POS_W    = POS_W_DEF,
  parameter logic [POS_W-1:0]  MAX_POS  = 16'd2000,
  parameter logic [31:0]       MIN_HALF = MIN_HALF_DEF,
  parameter logic [15:0]       HOME_MAX = 16'd4000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [POS_W-1:0] cmd_target,
  input  logic [31:0]      half_period,
  input  logic             home_req,
  input  logic             limit_switch,
  output logic             step,
  output logic             dir,
  output logic             enable,
  output logic [POS_W-1:0] position,
  output logic             busy,
  output logic             homed,
  output logic             fault
);

  state_t           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      hp_q, hp_d;
  logic [15:0]      pulses_q, pulses_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] tgt_q, tgt_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             homed_q, homed_d;
  logic             fault_q, fault_d;

  logic             lim_s;
  logic             start_home;
  logic [31:0]      hp_now;
  logic [POS_W-1:0] tgt_now;
  logic [POS_W-1:0] pos_next;

  sync2 u_lim_sync (
    .clock (clock),
    .reset (reset),
    .d     (limit_switch),
    .q     (lim_s)
  );

  assign hp_now  = (half_period < MIN_HALF) ? MIN_HALF : half_period;
  assign tgt_now = (cmd_target > MAX_POS) ? MAX_POS : cmd_target;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hp_d       = hp_q;
    pulses_d   = pulses_q;
    pos_d      = pos_q;
    tgt_d      = tgt_q;
    step_d     = step_q;
    dir_d      = dir_q;
    en_d       = en_q;
    homed_d    = homed_q;
    fault_d    = fault_q;
    start_home = 1'b0;
    pos_next   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);

    if (cmd_valid && state_q != ST_FAULT && state_q != ST_HOME)
      tgt_d = tgt_now;

    case (state_q)
      ST_IDLE: begin
        step_d = 1'b0;
        en_d   = homed_q;
        if (home_req) begin
          start_home = 1'b1;
        end else if (cmd_valid && homed_q && tgt_now != pos_q) begin
          state_d = ST_SETUP;
          dir_d   = (tgt_now > pos_q);
          en_d    = 1'b1;
          hp_d    = hp_now;
          cnt_d   = hp_now - 32'd1;
        end
      end

      ST_SETUP, ST_HIGH, ST_LOW: begin
        // Running into the home switch while heading down means the position is lost; park at 0.
        if (lim_s && !dir_q) begin
          state_d = ST_IDLE;
          pos_d   = '0;
          step_d  = 1'b0;
          en_d    = homed_q;
        end else if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (state_q == ST_SETUP) begin
          state_d = ST_HIGH;
          step_d  = 1'b1;
          cnt_d   = hp_q - 32'd1;
        end else if (state_q == ST_HIGH) begin
          state_d = ST_LOW;
          step_d  = 1'b0;
          cnt_d   = hp_q - 32'd1;
        end else begin
          pos_d = pos_next;
          if (pos_next == tgt_d) begin
            state_d = ST_IDLE;
            en_d    = homed_q;
          end else begin
            state_d = ST_SETUP;
            dir_d   = (tgt_d > pos_next);
            hp_d    = hp_now;
            cnt_d   = hp_now - 32'd1;
          end
        end
      end

      ST_HOME: begin
        if (lim_s) begin
          state_d = ST_IDLE;
          pos_d   = '0;
          homed_d = 1'b1;
          step_d  = 1'b0;
          en_d    = 1'b1;
        end else if (cnt_q != 32'd0) begin
          cnt_d = cnt_q - 32'd1;
        end else if (step_q) begin
          step_d = 1'b0;
          cnt_d  = hp_q - 32'd1;
        end else if (pulses_q + 16'd1 == HOME_MAX) begin
          state_d = ST_FAULT;
          step_d  = 1'b0;
          en_d    = 1'b0;
          fault_d = 1'b1;
          homed_d = 1'b0;
        end else begin
          pulses_d = pulses_q + 16'd1;
          step_d   = 1'b1;
          cnt_d    = hp_q - 32'd1;
        end
      end

      ST_FAULT: begin
        step_d  = 1'b0;
        en_d    = 1'b0;
        homed_d = 1'b0;
        if (home_req) start_home = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    // Homing opens with the first STEP high phase immediately.
    if (start_home) begin
      state_d  = ST_HOME;
      homed_d  = 1'b0;
      fault_d  = 1'b0;
      en_d     = 1'b1;
      dir_d    = 1'b0;
      step_d   = 1'b1;
      hp_d     = hp_now;
      cnt_d    = hp_now - 32'd1;
      pulses_d = 16'd0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hp_q     <= '0;
      pulses_q <= '0;
      pos_q    <= '0;
      tgt_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      homed_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hp_q     <= hp_d;
      pulses_q <= pulses_d;
      pos_q    <= pos_d;
      tgt_q    <= tgt_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      homed_q  <= homed_d;
      fault_q  <= fault_d;
    end
  end

  assign step     = step_q;
  assign dir      = dir_q;
  assign enable   = en_q;
  assign position = pos_q;
  assign busy     = busy_q;
  assign homed    = homed_q;
  assign fault    = fault_q;

endmodule
